// File: rtl/control_pkg.sv
// Shared types and encodings for the multi-cycle control unit: FSM states, opcodes,
// ALU operations, ALU operand sources and the decoded control bundle.
package control_pkg;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StErr
    } state_e;

    localparam logic [3:0] OP_LI     = 4'b0000;
    localparam logic [3:0] OP_LD     = 4'b0001;
    localparam logic [3:0] OP_ST     = 4'b0010;
    localparam logic [3:0] OP_MOV    = 4'b0011;
    localparam logic [3:0] OP_ADDSUB = 4'b0100;
    localparam logic [3:0] OP_SHIFT  = 4'b0101;
    localparam logic [3:0] OP_XOR    = 4'b0110;
    localparam logic [3:0] OP_ANDOR  = 4'b0111;
    localparam logic [3:0] OP_BANK   = 4'b1000;
    localparam logic [3:0] OP_JMP    = 4'b1001;
    localparam logic [3:0] OP_BEQ    = 4'b1010;
    localparam logic [3:0] OP_ANDI   = 4'b1011;
    localparam logic [3:0] OP_EXCESS = 4'b1100;
    localparam logic [3:0] OP_LDR    = 4'b1101;
    localparam logic [3:0] OP_STR    = 4'b1110;
    localparam logic [3:0] OP_RDX    = 4'b1111;

    localparam logic [2:0] ALU_ADD    = 3'b000;
    localparam logic [2:0] ALU_SHIFT  = 3'b001;
    localparam logic [2:0] ALU_EXCESS = 3'b010;
    localparam logic [2:0] ALU_XOR    = 3'b011;
    localparam logic [2:0] ALU_AND    = 3'b100;
    localparam logic [2:0] ALU_OR     = 3'b101;
    localparam logic [2:0] ALU_SUB    = 3'b110;
    localparam logic [2:0] ALU_RDX    = 3'b111;

    localparam logic [1:0] SRC_R0  = 2'd0;
    localparam logic [1:0] SRC_R3  = 2'd1;
    localparam logic [1:0] SRC_IMM = 2'd2;

    typedef struct packed {
        logic [3:0] reg_sel;
        logic [2:0] alu_op;
        logic [1:0] alu_src;
        logic       reg_imm;
        logic       mov;
        logic       bank_switch;
        logic       rdx;
        logic       load_regval;
        logic       store_regval;
        logic       mem_rd;
        logic       mem_wr;
        logic       reg_write;
        logic       beq;
        logic       jump;
    } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode decoder: opcode plus sub-select bit to the control bundle.
module control_decode
    import control_pkg::*;
#(
    parameter int unsigned MCODEBITS = 4
) (
    input  logic [MCODEBITS-1:0] instr,
    input  logic                 addsub,
    output ctrl_t                ctrl
);

    logic [3:0] op;
    assign op = 4'(instr);

    always_comb begin
        ctrl           = '0;
        ctrl.reg_write = 1'b1;
        case (op)
            OP_LI:     begin ctrl.reg_imm = 1'b1; ctrl.alu_src = SRC_IMM; end
            OP_LD:     begin ctrl.mem_rd = 1'b1; ctrl.reg_sel = 4'd2; ctrl.alu_src = SRC_IMM; end
            OP_ST:     begin ctrl.mem_wr = 1'b1; ctrl.reg_write = 1'b0; ctrl.alu_src = SRC_IMM; end
            OP_MOV:    begin ctrl.mov = 1'b1; ctrl.reg_sel = 4'd1; ctrl.alu_src = SRC_R3; end
            OP_ADDSUB: ctrl.alu_op = addsub ? ALU_ADD : ALU_SUB;
            OP_SHIFT:  ctrl.alu_op = ALU_SHIFT;
            OP_XOR:    ctrl.alu_op = ALU_XOR;
            OP_ANDOR:  ctrl.alu_op = addsub ? ALU_AND : ALU_OR;
            OP_BANK:   ctrl.bank_switch = 1'b1;
            OP_JMP:    begin ctrl.jump = 1'b1; ctrl.reg_write = 1'b0; ctrl.alu_src = SRC_IMM; end
            OP_BEQ:    begin
                ctrl.beq       = 1'b1;
                ctrl.reg_write = 1'b0;
                ctrl.alu_op    = ALU_SUB;
                ctrl.alu_src   = SRC_R3;
            end
            OP_ANDI:   begin ctrl.alu_op = ALU_AND; ctrl.alu_src = SRC_IMM; end
            OP_EXCESS: ctrl.alu_op = ALU_EXCESS;
            OP_LDR:    begin
                ctrl.mem_rd      = 1'b1;
                ctrl.load_regval = 1'b1;
                ctrl.reg_sel     = 4'd2;
                ctrl.alu_src     = SRC_R3;
            end
            OP_STR:    begin
                ctrl.mem_wr       = 1'b1;
                ctrl.store_regval = 1'b1;
                ctrl.reg_write    = 1'b0;
                ctrl.alu_src      = SRC_R3;
            end
            OP_RDX:    begin ctrl.rdx = 1'b1; ctrl.alu_op = ALU_RDX; end
            default:   ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencing control unit: FETCH/DECODE/EXEC/[MEM]/WB with registered strobes.
// Define CTRL_TIMEOUT_EN to bound MEM waits by TIMEOUT cycles and enter a sticky ERR state.
module multicycle_control
    import control_pkg::*;
#(
    parameter int unsigned OPWIDTH   = 3,
    parameter int unsigned MCODEBITS = 4,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 instr_valid,
    input  logic [MCODEBITS-1:0] instr,
    input  logic                 addsub,
    input  logic                 alu_zero,
    input  logic                 mem_ready,
    output logic                 instr_ready,
    output logic                 busy,
    output logic [3:0]           reg_sel,
    output logic [OPWIDTH-1:0]   alu_op,
    output logic [1:0]           alu_src,
    output logic                 reg_imm,
    output logic                 mov,
    output logic                 bank_switch,
    output logic                 rdx,
    output logic                 load_regval,
    output logic                 store_regval,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic                 wr_en,
    output logic                 pc_en,
    output logic                 branch_taken,
    output logic                 jump_en,
    output logic                 err
);

    state_e state;
    ctrl_t  ctrl_d;
    ctrl_t  ctrl_q;

    control_decode #(.MCODEBITS(MCODEBITS)) u_decode (
        .instr  (instr),
        .addsub (addsub),
        .ctrl   (ctrl_d)
    );

    // Mode strobes come straight from the bundle latched on the handshake edge.
    assign reg_sel      = ctrl_q.reg_sel;
    assign alu_op       = OPWIDTH'(ctrl_q.alu_op);
    assign alu_src      = ctrl_q.alu_src;
    assign reg_imm      = ctrl_q.reg_imm;
    assign mov          = ctrl_q.mov;
    assign bank_switch  = ctrl_q.bank_switch;
    assign rdx          = ctrl_q.rdx;
    assign load_regval  = ctrl_q.load_regval;
    assign store_regval = ctrl_q.store_regval;

`ifdef CTRL_TIMEOUT_EN
    localparam int unsigned CntW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CntW-1:0] mem_cnt;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= StFetch;
            ctrl_q       <= '0;
            instr_ready  <= 1'b1;
            busy         <= 1'b0;
            mem_rd       <= 1'b0;
            mem_wr       <= 1'b0;
            wr_en        <= 1'b0;
            pc_en        <= 1'b0;
            branch_taken <= 1'b0;
            jump_en      <= 1'b0;
`ifdef CTRL_TIMEOUT_EN
            err          <= 1'b0;
            mem_cnt      <= '0;
`endif
        end else begin
            wr_en        <= 1'b0;
            pc_en        <= 1'b0;
            branch_taken <= 1'b0;
            jump_en      <= 1'b0;
            case (state)
                StFetch: begin
                    if (instr_valid) begin
                        state       <= StDecode;
                        ctrl_q      <= ctrl_d;
                        instr_ready <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                StDecode: state <= StExec;
                StExec: begin
                    if (ctrl_q.mem_rd || ctrl_q.mem_wr) begin
                        state  <= StMem;
                        mem_rd <= ctrl_q.mem_rd;
                        mem_wr <= ctrl_q.mem_wr;
`ifdef CTRL_TIMEOUT_EN
                        mem_cnt <= '0;
`endif
                    end else begin
                        state        <= StWb;
                        wr_en        <= ctrl_q.reg_write;
                        pc_en        <= 1'b1;
                        branch_taken <= ctrl_q.beq && alu_zero;
                        jump_en      <= ctrl_q.jump;
                    end
                end
                StMem: begin
                    // mem_ready takes priority over an expiring timeout.
                    if (mem_ready) begin
                        state  <= StWb;
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        wr_en  <= ctrl_q.reg_write;
                        pc_en  <= 1'b1;
                    end
`ifdef CTRL_TIMEOUT_EN
                    else if (mem_cnt == CntW'(TIMEOUT - 1)) begin
                        state  <= StErr;
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        err    <= 1'b1;
                    end else begin
                        mem_cnt <= mem_cnt + 1'b1;
                    end
`endif
                end
                StWb: begin
                    state       <= StFetch;
                    instr_ready <= 1'b1;
                    busy        <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control; covers the timeout path when
// CTRL_TIMEOUT_EN is defined, otherwise the unbounded MEM wait.
module tb_multicycle_control;

`ifdef CTRL_TIMEOUT_EN
    localparam int unsigned TbTimeout = 4;
`else
    localparam int unsigned TbTimeout = 16;
`endif

    logic       Clk = 1'b0;
    logic       Reset, instr_valid, addsub, alu_zero, mem_ready;
    logic [3:0] instr;
    logic       instr_ready, busy, reg_imm, mov, bank_switch, rdx, load_regval, store_regval;
    logic       mem_rd, mem_wr, wr_en, pc_en, branch_taken, jump_en, err;
    logic [3:0] reg_sel;
    logic [2:0] alu_op;
    logic [1:0] alu_src;

    int n_cmp = 0;
    int n_bad = 0;

    multicycle_control #(.OPWIDTH(3), .MCODEBITS(4), .TIMEOUT(TbTimeout)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .addsub       (addsub),
        .alu_zero     (alu_zero),
        .mem_ready    (mem_ready),
        .instr_ready  (instr_ready),
        .busy         (busy),
        .reg_sel      (reg_sel),
        .alu_op       (alu_op),
        .alu_src      (alu_src),
        .reg_imm      (reg_imm),
        .mov          (mov),
        .bank_switch  (bank_switch),
        .rdx          (rdx),
        .load_regval  (load_regval),
        .store_regval (store_regval),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .wr_en        (wr_en),
        .pc_en        (pc_en),
        .branch_taken (branch_taken),
        .jump_en      (jump_en),
        .err          (err)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Present one instruction in the current FETCH cycle; returns in cycle 1 (DECODE).
    task automatic issue(input logic [3:0] op, input logic as);
        instr_valid = 1'b1;
        instr       = op;
        addsub      = as;
        step();
        instr_valid = 1'b0;
    endtask

    int acc_cyc[$];
    int wr_cnt;

    initial begin
        Reset = 1'b1; instr_valid = 1'b0; instr = '0; addsub = 1'b0;
        alu_zero = 1'b0; mem_ready = 1'b0;
        step(); step();
        Reset = 1'b0;
        step();
        check_eq("rst_instr_ready", instr_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_strobes", {wr_en, pc_en, mem_rd, mem_wr, branch_taken, jump_en}, 0);
        check_eq("rst_mode", {reg_sel, alu_op, alu_src, reg_imm, mov, rdx}, 0);
        check_eq("rst_err", err, 0);

        // add: addsub = 1 selects add
        issue(4'b0100, 1'b1);
        check_eq("add_c1_busy", {busy, instr_ready}, 2'b10);
        check_eq("add_c1_ctrl", {alu_op, reg_sel, alu_src}, {3'b000, 4'd0, 2'd0});
        check_eq("add_c1_wr", wr_en, 0);
        step();
        check_eq("add_c2_pulses", {wr_en, pc_en}, 2'b00);
        step();
        check_eq("add_c3_pulses", {wr_en, pc_en}, 2'b11);
        step();
        check_eq("add_c4_pulses", {wr_en, pc_en}, 2'b00);
        check_eq("add_c4_ready", instr_ready, 1);

        // load, mem_ready on third MEM cycle
        issue(4'b0001, 1'b0);
        step();
        check_eq("ld_c2_mem_rd", mem_rd, 0);
        step();
        check_eq("ld_c3_mem_rd", mem_rd, 1);
        step();
        check_eq("ld_c4_mem_rd", mem_rd, 1);
        step();
        check_eq("ld_c5_mem_rd", mem_rd, 1);
        check_eq("ld_c5_wr", wr_en, 0);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        check_eq("ld_c6_wb", {mem_rd, wr_en, pc_en}, 3'b011);
        check_eq("ld_c6_reg_sel", reg_sel, 2);
        step();
        check_eq("ld_c7_ready", instr_ready, 1);

        // beq taken
        issue(4'b1010, 1'b0);
        check_eq("beq_alu_op", alu_op, 3'b110);
        step();
        alu_zero = 1'b1;
        step();
        alu_zero = 1'b0;
        check_eq("beq1_wb", {branch_taken, pc_en, wr_en}, 3'b110);
        step();
        check_eq("beq1_c4", {branch_taken, pc_en}, 2'b00);

        // beq not taken
        issue(4'b1010, 1'b0);
        step();
        step();
        check_eq("beq0_wb", {branch_taken, pc_en, wr_en}, 3'b010);
        step();

        // jump
        issue(4'b1001, 1'b0);
        step();
        step();
        check_eq("jmp_wb", {jump_en, pc_en, wr_en}, 3'b110);
        step();

        // reset during second MEM cycle of a store
        issue(4'b0010, 1'b0);
        step();
        step();
        check_eq("strst_c3_mem_wr", mem_wr, 1);
        step();
        check_eq("strst_c4_mem_wr", mem_wr, 1);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check_eq("strst_after", {mem_wr, instr_ready, busy}, 3'b010);
        for (int i = 0; i < 4; i++) begin
            check_eq("strst_no_pulse", {wr_en, pc_en}, 2'b00);
            step();
        end

        // three back-to-back xor with instr_valid held
        wr_cnt = 0;
        instr_valid = 1'b1;
        instr = 4'b0110;
        addsub = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            check_eq("xor_no_accept_busy", busy & instr_ready, 0);
            if (instr_ready) acc_cyc.push_back(cyc);
            if (wr_en) wr_cnt++;
            if (cyc == 1) check_eq("xor_alu_op", alu_op, 3'b011);
            step();
        end
        instr_valid = 1'b0;
        check_eq("xor_accepts", acc_cyc.size(), 3);
        check_eq("xor_wr_pulses", wr_cnt, 3);
        if (acc_cyc.size() == 3) begin
            check_eq("xor_acc1", acc_cyc[1], 4);
            check_eq("xor_acc2", acc_cyc[2], 8);
        end
        step();
        step();
        step();

        // and/or with addsub = 0 selects or
        issue(4'b0111, 1'b0);
        check_eq("or_alu_op", alu_op, 3'b101);
        step();
        step();
        step();

`ifdef CTRL_TIMEOUT_EN
        // store times out after TIMEOUT MEM cycles
        issue(4'b0010, 1'b0);
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("to_mem_wr", {mem_wr, err}, 2'b10);
        end
        step();
        check_eq("to_err", {mem_wr, err, busy, instr_ready}, 4'b0110);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("to_err_hold", {err, busy, instr_ready, pc_en}, 4'b1100);
        end
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check_eq("to_after_rst", {instr_ready, err}, 2'b10);

        // mem_ready on the expiry cycle wins
        issue(4'b0010, 1'b0);
        step(); step(); step(); step(); step();
        check_eq("to_edge_mem_wr", mem_wr, 1);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        check_eq("to_edge_wb", {pc_en, err, mem_wr, wr_en}, 4'b1000);
        step();
        check_eq("to_edge_ready", instr_ready, 1);
`else
        // MEM waits indefinitely
        issue(4'b0010, 1'b0);
        step();
        step();
        check_eq("wait_c3_mem_wr", mem_wr, 1);
        repeat (19) step();
        check_eq("wait_c22", {mem_wr, err, busy}, 3'b101);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        check_eq("wait_wb", {pc_en, wr_en, mem_wr, err}, 4'b1000);
        step();
        check_eq("wait_ready", instr_ready, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Registered, multi-cycle control unit that generalises the opcode decoder into a sequencing FSM. It sits between instruction fetch and the datapath. It accepts one instruction per handshake and walks it through DECODE, EXEC, optional MEM and WB states. It drives registered datapath strobes, stalls on a memory ready handshake, and pulses the PC enable once per retired instruction.

## Interface
Parameters:
- OPWIDTH, 3, ALU operation code width
- MCODEBITS, 4, opcode width taken from the instruction
- TIMEOUT, 16, maximum MEM cycles before error (used only with the timeout macro)

Ports:
- Clk  in  1  clock
- Reset  in  1  synchronous, active-high reset
- instr_valid  in  1  fetch has an instruction
- instr  in  MCODEBITS  opcode
- addsub  in  1  sub-select bit (add vs sub, and vs or)
- alu_zero  in  1  ALU zero flag, sampled in EXEC
- mem_ready  in  1  data memory has completed the access
- instr_ready  out  1  high in FETCH; handshake completes when instr_valid && instr_ready
- busy  out  1  high in any state other than FETCH
- reg_sel  out  4  destination register
- alu_op  out  OPWIDTH  ALU operation
- alu_src  out  2  ALU operand source: 0 = R0, 1 = R3, 2 = imm
- reg_imm, mov, bank_switch, rdx, load_regval, store_regval  out  1 each  mode strobes, held from DECODE through WB
- mem_rd, mem_wr  out  1  memory strobes, high only in MEM
- wr_en  out  1  register write, one-cycle pulse in WB
- pc_en  out  1  one-cycle pulse in WB
- branch_taken  out  1  high in WB when a beq condition held
- jump_en  out  1  high in WB for a jump
- err  out  1  sticky timeout error

## Operation
- States are FETCH, DECODE, EXEC, MEM, WB and ERR.
  - FETCH → DECODE on handshake.
  - DECODE → EXEC.
  - EXEC → MEM for load, store, load-via-register and store-via-register (opcodes 0001, 0010, 1101, 1110).
  - EXEC → WB for every other opcode.
  - MEM → WB when mem_ready is high.
  - WB → FETCH.
- DECODE latches instr and addsub and registers all control outputs through the opcode map.
- Opcode map:
  - 0000: load immediate
  - 0011: mov
  - 0100: add/sub, alu_op 000/110
  - 0101: shift, 001
  - 0110: xor, 011
  - 0111: and/or, 100/101
  - 1000: bank switch
  - 1001: jump
  - 1010: beq, 110
  - 1011: and-immediate
  - 1100: excess, 010
  - 1111: rdx, 111
- wr_en pulses in WB for every opcode except store, store-via-register, beq and jump.
- branch_taken = beq && the alu_zero value captured in EXEC.
- instr_valid is ignored outside FETCH.
- mem_ready is ignored outside MEM.
- An undefined condition never occurs: all 16 opcodes are defined.

## Timing
- Reset:
  - State goes to FETCH.
  - All outputs are 0, except instr_ready = 1.
  - err is cleared.
  - Counters are cleared.
  - An in-flight instruction is abandoned and no strobe follows.
- Handshake at cycle 0. DECODE in cycle 1. EXEC in cycle 2.
- Non-memory instruction: WB in cycle 3, FETCH in cycle 4. Throughput is 1 instruction per 4 cycles.
- Memory instruction: MEM from cycle 3, held until the cycle where mem_ready = 1 (inclusive). WB follows in the next cycle.
- mem_ready high on the first MEM cycle gives a 5-cycle instruction.
- Mode strobes change only on the DECODE edge and on Reset.

## Configuration
- `CTRL_TIMEOUT_EN` defined:
  - An 8-bit-minimum counter counts MEM cycles.
  - When TIMEOUT cycles pass without mem_ready, the next state is ERR.
  - In ERR, mem_rd and mem_wr drop and err = 1.
  - ERR stays until Reset. instr_ready = 0 and busy = 1 while in ERR.
  - If mem_ready arrives on the expiry cycle, it wins and WB proceeds.
- `CTRL_TIMEOUT_EN` undefined:
  - MEM waits indefinitely.
  - err is tied to 0.
  - ERR is unreachable and the counter is not built.

## Structure
- Package control_pkg holds:
  - the state enum
  - the opcode localparams (OP_LI … OP_RDX)
  - the ALU op localparams
  - the alu_src encodings
- Sub-module control_decode is purely combinational: opcode + addsub → control bundle. It is instantiated once; its output is registered in DECODE.

## Test plan
- Reset, then instr = 0100 with addsub = 1 accepted at cycle 0 → alu_op = 000, reg_sel = 0, alu_src = 0. wr_en and pc_en pulse in cycle 3 only. instr_ready returns in cycle 4.
- Load (0001) with mem_ready raised in the third MEM cycle → mem_rd high cycles 3–5, WB in cycle 6, wr_en pulse with reg_sel = 2.
- beq (1010) with alu_zero = 1 in EXEC → branch_taken = 1 and pc_en = 1 in WB, wr_en = 0. Repeat with alu_zero = 0 → branch_taken = 0.
- `CTRL_TIMEOUT_EN`, TIMEOUT = 4, store (0010) with mem_ready held at 0 → mem_wr is high for 4 cycles, then err = 1 and mem_wr = 0. err holds until Reset; after Reset, instr_ready = 1.
- Reset asserted in the second MEM cycle of a store → the next cycle is FETCH with mem_wr = 0. No wr_en or pc_en pulse follows.
- instr_valid held high across three back-to-back xor (0110) instructions → exactly one accept per 4 cycles. No accept while busy = 1. Three wr_en pulses in total.
